// File: rtl/apb4_rtc_cfg_seq.sv
// apb4_rtc_cfg_seq
// APB4 master that brings up an RTC and services its interrupt.
// A start pulse programs CTRL (write-enable, counter off), PSCR, CNT, ALRM and
// finally CTRL (enable + irq enables). Before each clock-domain-crossing write
// it polls SSTA until the write-ready bit is set. When idle with the interrupt
// pending, it reads ISTA, which the RTC clears on read, and reports the flags.
// Only one APB transfer is outstanding at any time.
//
// Ports
//   clk_i, rst_n_i        APB clock, async active-low reset
//   start_i               begin config sequence (accepted only when idle)
//   cfg_pscr_i/cnt_i/alrm_i, cfg_ie_i   values programmed by the sequence
//   irq_i                 RTC interrupt level
//   busy_o, done_o, err_o sequence status (err_o sticky until next start)
//   ista_vld_o, ista_o    ISTA flags from the last interrupt service read
//   p*_o / p*_i           APB4 master interface

module apb4_rtc_cfg_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          POLL_MAX  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [31:0] cfg_pscr_i,
  input  logic [31:0] cfg_cnt_i,
  input  logic [31:0] cfg_alrm_i,
  input  logic [2:0]  cfg_ie_i,
  input  logic        irq_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        ista_vld_o,
  output logic [2:0]  ista_o,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  output logic [3:0]  pstrb_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  // state    | meaning
  // ---------+---------------------------------------------------------
  // IDLE     | waiting for start_i or irq_i
  // W_CTRL0  | write CTRL = 0x01 (write enable, counter stopped)
  // POLL_A   | read SSTA until write-ready, then program PSCR
  // W_PSCR   | write prescaler
  // POLL_B   | read SSTA until write-ready, then program CNT
  // W_CNT    | write initial count
  // POLL_C   | read SSTA until write-ready, then program ALRM
  // W_ALRM   | write alarm value
  // W_CTRL1  | write CTRL = {1, ie, 0} (counter running)
  // DONE     | one-cycle done_o pulse
  // R_ISTA   | interrupt service read of ISTA

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_MAX);

  localparam logic [31:0] A_CTRL = BASE_ADDR + 32'h00;
  localparam logic [31:0] A_PSCR = BASE_ADDR + 32'h04;
  localparam logic [31:0] A_CNT  = BASE_ADDR + 32'h08;
  localparam logic [31:0] A_ALRM = BASE_ADDR + 32'h0C;
  localparam logic [31:0] A_ISTA = BASE_ADDR + 32'h10;
  localparam logic [31:0] A_SSTA = BASE_ADDR + 32'h14;

  typedef enum logic [3:0] {
    ST_IDLE, ST_W_CTRL0, ST_POLL_A, ST_W_PSCR, ST_POLL_B, ST_W_CNT,
    ST_POLL_C, ST_W_ALRM, ST_W_CTRL1, ST_DONE, ST_R_ISTA
  } state_t;

  // Every transfer state starts in PH_GAP, so psel drops for at least one
  // cycle after each completion and a failed poll re-reads after one idle cycle.
  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] poll_q, poll_d;
  logic [31:0]      pscr_q, cnt_q, alrm_q;
  logic [2:0]       ie_q;
  logic             err_q, err_d;
  logic [2:0]       ista_q, ista_d;
  logic             ista_vld_q, ista_vld_d;
  logic             cfg_cap;

  logic             xfer_state;
  logic [31:0]      xfer_addr;
  logic [31:0]      xfer_data;
  logic             xfer_wr;
  logic             xfer_done;

  // Only bits [2:0] (ISTA) and [1] (SSTA) of read data carry meaning.
  logic unused_prdata;
  assign unused_prdata = ^{prdata_i[31:3]};

  always_comb begin
    xfer_state = 1'b1;
    xfer_addr  = 32'h0;
    xfer_data  = 32'h0;
    xfer_wr    = 1'b0;
    case (state_q)
      ST_W_CTRL0: begin xfer_addr = A_CTRL; xfer_data = 32'h1;    xfer_wr = 1'b1; end
      ST_W_PSCR:  begin xfer_addr = A_PSCR; xfer_data = pscr_q;   xfer_wr = 1'b1; end
      ST_W_CNT:   begin xfer_addr = A_CNT;  xfer_data = cnt_q;    xfer_wr = 1'b1; end
      ST_W_ALRM:  begin xfer_addr = A_ALRM; xfer_data = alrm_q;   xfer_wr = 1'b1; end
      ST_W_CTRL1: begin
        xfer_addr = A_CTRL;
        xfer_data = {27'h0, 1'b1, ie_q, 1'b0};
        xfer_wr   = 1'b1;
      end
      ST_POLL_A, ST_POLL_B, ST_POLL_C: xfer_addr = A_SSTA;
      ST_R_ISTA:  xfer_addr = A_ISTA;
      default:    xfer_state = 1'b0;
    endcase
  end

  assign psel_o    = xfer_state && (phase_q != PH_GAP);
  assign penable_o = xfer_state && (phase_q == PH_ACCESS);
  assign pwrite_o  = psel_o && xfer_wr;
  assign paddr_o   = psel_o ? xfer_addr : 32'h0;
  assign pwdata_o  = pwrite_o ? xfer_data : 32'h0;
  assign pstrb_o   = pwrite_o ? 4'hF : 4'h0;
  assign xfer_done = penable_o && pready_i;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    poll_d     = poll_q;
    err_d      = err_q;
    ista_d     = ista_q;
    ista_vld_d = 1'b0;
    cfg_cap    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = PH_GAP;
        if (start_i) begin
          cfg_cap = 1'b1;
          err_d   = 1'b0;
          state_d = ST_W_CTRL0;
        end else if (irq_i) begin
          state_d = ST_R_ISTA;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        case (phase_q)
          PH_GAP:   phase_d = PH_SETUP;
          PH_SETUP: phase_d = PH_ACCESS;
          default:  phase_d = PH_ACCESS;
        endcase
        if (xfer_done) begin
          phase_d = PH_GAP;
          if (pslverr_i) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            case (state_q)
              ST_W_CTRL0: begin state_d = ST_POLL_A; poll_d = '0; end
              ST_W_PSCR:  begin state_d = ST_POLL_B; poll_d = '0; end
              ST_W_CNT:   begin state_d = ST_POLL_C; poll_d = '0; end
              ST_W_ALRM:  state_d = ST_W_CTRL1;
              ST_W_CTRL1: state_d = ST_DONE;
              ST_R_ISTA: begin
                ista_d     = prdata_i[2:0];
                ista_vld_d = 1'b1;
                state_d    = ST_IDLE;
              end
              ST_POLL_A, ST_POLL_B, ST_POLL_C: begin
                if (prdata_i[1]) begin
                  case (state_q)
                    ST_POLL_A: state_d = ST_W_PSCR;
                    ST_POLL_B: state_d = ST_W_CNT;
                    default:   state_d = ST_W_ALRM;
                  endcase
                end else begin
                  if (poll_q != POLL_LAST) begin
                    poll_d = poll_q + CNT_W'(1);
                  end
                  // This read was the POLL_MAX-th without write-ready.
                  if (poll_q + CNT_W'(1) >= POLL_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                  end
                end
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_GAP;
      poll_q     <= '0;
      err_q      <= 1'b0;
      ista_q     <= 3'b0;
      ista_vld_q <= 1'b0;
      pscr_q     <= 32'h0;
      cnt_q      <= 32'h0;
      alrm_q     <= 32'h0;
      ie_q       <= 3'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      poll_q     <= poll_d;
      err_q      <= err_d;
      ista_q     <= ista_d;
      ista_vld_q <= ista_vld_d;
      if (cfg_cap) begin
        pscr_q <= cfg_pscr_i;
        cnt_q  <= cfg_cnt_i;
        alrm_q <= cfg_alrm_i;
        ie_q   <= cfg_ie_i;
      end
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign err_o      = err_q;
  assign ista_vld_o = ista_vld_q;
  assign ista_o     = ista_q;

endmodule

// File: tb/tb_apb4_rtc_cfg_seq.sv
module tb_apb4_rtc_cfg_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT (POLL_MAX = 8)
  logic        start = 1'b0, irq = 1'b0;
  logic [31:0] cfg_pscr = 0, cfg_cnt = 0, cfg_alrm = 0;
  logic [2:0]  cfg_ie = 0;
  logic        busy, done, err, ista_vld;
  logic [2:0]  ista;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;

  apb4_rtc_cfg_seq #(.BASE_ADDR(32'h0), .POLL_MAX(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .cfg_pscr_i(cfg_pscr), .cfg_cnt_i(cfg_cnt), .cfg_alrm_i(cfg_alrm), .cfg_ie_i(cfg_ie),
    .irq_i(irq), .busy_o(busy), .done_o(done), .err_o(err),
    .ista_vld_o(ista_vld), .ista_o(ista),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr));

  // second DUT (POLL_MAX = 4) against a slave whose SSTA never becomes ready
  logic        start2 = 1'b0;
  logic        busy2, done2, err2, ista_vld2;
  logic [2:0]  ista2;
  logic [31:0] paddr2, pwdata2;
  logic        psel2, penable2, pwrite2;
  logic [3:0]  pstrb2;
  logic [31:0] prdata2 = 32'h0;
  logic        pready2 = 1'b1, pslverr2 = 1'b0, irq2 = 1'b0;

  apb4_rtc_cfg_seq #(.BASE_ADDR(32'h0), .POLL_MAX(4)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start2),
    .cfg_pscr_i(32'h5), .cfg_cnt_i(32'h6), .cfg_alrm_i(32'h7), .cfg_ie_i(3'b001),
    .irq_i(irq2), .busy_o(busy2), .done_o(done2), .err_o(err2),
    .ista_vld_o(ista_vld2), .ista_o(ista2),
    .paddr_o(paddr2), .psel_o(psel2), .penable_o(penable2), .pwrite_o(pwrite2),
    .pwdata_o(pwdata2), .pstrb_o(pstrb2),
    .prdata_i(prdata2), .pready_i(pready2), .pslverr_i(pslverr2));

  int total = 0, bad = 0;

  // slave model knobs and observations
  logic [31:0] wa_q[$], wd_q[$];
  int ssta_idx, ssta_skip, ssta_low;
  int ssta_reads, ista_reads, done_cnt, vld_cnt, done_at_ista;
  int wait_cycles, stab_viol, strb_viol, waits_left;
  bit wait_arm = 0, err_arm = 0;
  logic [31:0] wait_addr = 0, err_addr = 0;
  int wait_n = 0;
  logic [2:0] ista_val = 0;
  logic [31:0] sv_addr, sv_data;
  logic sv_wr;
  int ssta2_reads = 0, pscr2_writes = 0, writes2 = 0, done2_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wa_q.delete(); wd_q.delete();
    ssta_idx = 0; ssta_skip = 0; ssta_low = 0;
    ssta_reads = 0; ista_reads = 0; done_cnt = 0; vld_cnt = 0; done_at_ista = -1;
    wait_cycles = 0; stab_viol = 0; strb_viol = 0;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, {31'h0, busy}, 32'h0);
  endtask

  // APB slave for the main DUT, acting on the falling edge
  initial begin
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0; waits_left = 0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (ista_vld) vld_cnt++;
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
      if (!rst_n) begin
        waits_left = 0;
      end else if (psel && !penable) begin
        sv_addr = paddr; sv_data = pwdata; sv_wr = pwrite;
        if (pstrb !== (pwrite ? 4'hF : 4'h0)) strb_viol++;
        waits_left = 0;
        if (wait_arm && pwrite && paddr == wait_addr) begin
          waits_left = wait_n;
          wait_arm = 0;
        end
      end else if (psel && penable) begin
        if (paddr !== sv_addr || pwdata !== sv_data || pwrite !== sv_wr) stab_viol++;
        if (waits_left > 0) begin
          waits_left--;
          wait_cycles++;
        end else begin
          pready = 1'b1;
          if (err_arm && paddr == err_addr) begin
            pslverr = 1'b1;
            err_arm = 0;
          end
          if (pwrite) begin
            wa_q.push_back(paddr);
            wd_q.push_back(pwdata);
          end else if (paddr == 32'h14) begin
            prdata = (ssta_idx >= ssta_skip && ssta_idx < ssta_skip + ssta_low) ? 32'h0 : 32'h2;
            ssta_idx++;
            ssta_reads++;
          end else if (paddr == 32'h10) begin
            prdata = {29'h0, ista_val};
            ista_reads++;
            done_at_ista = done_cnt;
          end
        end
      end
    end
  end

  // observer for the second DUT (its slave always answers at once)
  initial begin
    forever begin
      @(negedge clk);
      if (done2) done2_cnt++;
      if (psel2 && penable2) begin
        if (pwrite2) begin
          writes2++;
          if (paddr2 == 32'h04) pscr2_writes++;
        end else if (paddr2 == 32'h14) begin
          ssta2_reads++;
        end
      end
    end
  end

  logic [31:0] exp_a[5] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h00};
  logic [31:0] exp_d[5] = '{32'h1, 32'h8, 32'h100, 32'h200, 32'h14};
  int n;

  initial begin
    clr();
    // reset state
    cyc(3);
    chk("rst_psel", {31'h0, psel}, 0);
    chk("rst_penable", {31'h0, penable}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_err", {31'h0, err}, 0);
    chk("rst_ista", {28'h0, ista_vld, ista}, 0);
    chk("rst_paddr", paddr, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    cyc(2);

    // 1: basic bring-up, SSTA ready at once
    clr();
    cfg_pscr = 32'h8; cfg_cnt = 32'h100; cfg_alrm = 32'h200; cfg_ie = 3'b010;
    pulse_start();
    chk("t1_busy", {31'h0, busy}, 1);
    wait_idle(200, "t1_idle");
    chk("t1_nwr", wa_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t1_wa%0d", i), wa_q[i], exp_a[i]);
      chk($sformatf("t1_wd%0d", i), wd_q[i], exp_d[i]);
    end
    chk("t1_ssta", ssta_reads, 3);
    chk("t1_done", done_cnt, 1);
    chk("t1_err", {31'h0, err}, 0);
    chk("t1_strb", strb_viol, 0);

    // 2: poll retries and wait states on W_CNT; inputs changed mid-sequence
    clr();
    ssta_skip = 2; ssta_low = 5;
    wait_arm = 1; wait_addr = 32'h08; wait_n = 3;
    cfg_pscr = 32'h3; cfg_cnt = 32'hABCD; cfg_alrm = 32'h1234; cfg_ie = 3'b111;
    pulse_start();
    cfg_pscr = 32'hDEAD; cfg_ie = 3'b000;
    wait_idle(400, "t2_idle");
    chk("t2_ssta", ssta_reads, 8);
    chk("t2_waits", wait_cycles, 3);
    chk("t2_stable", stab_viol, 0);
    chk("t2_pscr", wd_q[1], 32'h3);
    chk("t2_cnt", wd_q[2], 32'hABCD);
    chk("t2_ctrl1", wd_q[4], 32'h1E);
    chk("t2_done", done_cnt, 1);
    chk("t2_err", {31'h0, err}, 0);

    // 3: poll timeout on the POLL_MAX=4 instance
    @(posedge clk); #1; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    n = 0;
    while (busy2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t3_idle", {31'h0, busy2}, 0);
    chk("t3_ssta", ssta2_reads, 4);
    chk("t3_err", {31'h0, err2}, 1);
    chk("t3_done", done2_cnt, 0);
    chk("t3_pscr", pscr2_writes, 0);
    chk("t3_nwr", writes2, 1);

    // 4: pslverr on W_ALRM, then a clean retry
    clr();
    err_arm = 1; err_addr = 32'h0C;
    cfg_pscr = 32'h1; cfg_cnt = 32'h2; cfg_alrm = 32'h3; cfg_ie = 3'b001;
    pulse_start();
    wait_idle(200, "t4_idle");
    chk("t4_nwr", wa_q.size(), 4);
    chk("t4_last", wa_q[3], 32'h0C);
    chk("t4_err", {31'h0, err}, 1);
    chk("t4_done", done_cnt, 0);
    clr();
    pulse_start();
    chk("t4_errclr", {31'h0, err}, 0);
    wait_idle(200, "t4_idle2");
    chk("t4_nwr2", wa_q.size(), 5);
    chk("t4_ctrl1", wd_q[4], 32'h12);
    chk("t4_done2", done_cnt, 1);

    // 5a: interrupt service from idle
    clr();
    ista_val = 3'b100;
    @(posedge clk); #1; irq = 1'b1;
    n = 0;
    while (!ista_vld && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    irq = 1'b0;
    chk("t5_vld", {31'h0, ista_vld}, 1);
    chk("t5_ista", {29'h0, ista}, 32'h4);
    chk("t5_reads", ista_reads, 1);
    cyc(1);
    chk("t5_pulse", {31'h0, ista_vld}, 0);
    cyc(3);
    chk("t5_vldcnt", vld_cnt, 1);

    // 5b: start and irq together -> config first, ISTA after done
    clr();
    ista_val = 3'b011;
    @(posedge clk); #1; start = 1'b1; irq = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (!ista_vld && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    irq = 1'b0;
    chk("t5b_vld", {31'h0, ista_vld}, 1);
    chk("t5b_ista", {29'h0, ista}, 32'h3);
    chk("t5b_order", done_at_ista, 1);
    chk("t5b_nwr", wa_q.size(), 5);
    cyc(3);
    chk("t5b_reads", ista_reads, 1);

    // 6: reset during W_PSCR access
    clr();
    wait_arm = 1; wait_addr = 32'h04; wait_n = 4;
    pulse_start();
    n = 0;
    while (!(psel && penable && paddr == 32'h04) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_found", {31'h0, psel && penable}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_psel", {31'h0, psel}, 0);
    chk("t6_penable", {31'h0, penable}, 0);
    chk("t6_busy", {31'h0, busy}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    cyc(4);
    chk("t6_idle", {31'h0, busy}, 0);
    chk("t6_psel2", {31'h0, psel}, 0);
    chk("t6_done", done_cnt, 0);
    chk("t6_err", {31'h0, err}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
